// File: rtl/gb_if_responder_pkg.sv
// Shared definitions for the global-buffer transfer responder.
//   INFO_WIDTH  : width of the transfer descriptor {type[3:1], dir[0]}
//   DIR_BIT     : descriptor bit selecting read (1, host -> GB) or write (0, GB -> host)
//   state_e     : responder FSM states
//   conv_mode_e : width converter mode (pack pad beats into a word / split a word into beats)
package gb_if_responder_pkg;

    localparam int unsigned INFO_WIDTH = 4;
    localparam int unsigned DIR_BIT    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_e;

    typedef enum logic {
        CONV_PACK  = 1'b0,
        CONV_SPLIT = 1'b1
    } conv_mode_e;

endpackage

// File: rtl/if_width_conv.sv
// Width converter between the wide GB word and the narrow pad bus.
// One buffer and one beat counter serve both directions:
//   CONV_PACK  : pad beats fill the buffer low slice first; buf_full sets on the
//                last beat and clears on word_take.
//   CONV_SPLIT : word_load fills the buffer; beat_out always shows the low slice,
//                each beat_out_take shifts the buffer down one beat; buf_full
//                clears after the last beat is taken.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          synchronous discard of any partial word
//   mode           direction select
//   beat_in_val    pad beat accepted (pack)      beat_in_data  pad beat
//   word_take      GB accepted the packed word (pack)
//   word_load      GB word accepted (split)      word_in       GB word
//   beat_out_take  host accepted the current beat (split)
//   buf_full       buffer holds a complete / not-yet-drained word
//   word_out       buffer contents               beat_out      low beat of buffer
//   last_beat      beat counter is at the final beat of a word
module if_width_conv
    import gb_if_responder_pkg::*;
#(
    parameter int unsigned PORT_WIDTH = 128,
    parameter int unsigned PAD_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  conv_mode_e            mode,
    input  logic                  beat_in_val,
    input  logic [PAD_WIDTH-1:0]  beat_in_data,
    input  logic                  word_take,
    input  logic                  word_load,
    input  logic [PORT_WIDTH-1:0] word_in,
    input  logic                  beat_out_take,
    output logic                  buf_full,
    output logic [PORT_WIDTH-1:0] word_out,
    output logic [PAD_WIDTH-1:0]  beat_out,
    output logic                  last_beat
);

    localparam int unsigned BEATS = PORT_WIDTH / PAD_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [PORT_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  full_q, full_d;

    always_comb begin
        buf_d      = buf_q;
        beat_cnt_d = beat_cnt_q;
        full_d     = full_q;
        if (clear) begin
            buf_d      = '0;
            beat_cnt_d = '0;
            full_d     = 1'b0;
        end else if (mode == CONV_PACK) begin
            // The FSM never offers a pad beat while full, so take and fill never collide.
            if (word_take) begin
                full_d = 1'b0;
            end
            if (beat_in_val) begin
                for (int unsigned i = 0; i < BEATS; i++) begin
                    if (beat_cnt_q == CNT_W'(i)) begin
                        buf_d[i*PAD_WIDTH +: PAD_WIDTH] = beat_in_data;
                    end
                end
                if (beat_cnt_q == LAST) begin
                    beat_cnt_d = '0;
                    full_d     = 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
        end else begin
            if (word_load) begin
                buf_d      = word_in;
                beat_cnt_d = '0;
                full_d     = 1'b1;
            end else if (beat_out_take) begin
                buf_d = buf_q >> PAD_WIDTH;
                if (beat_cnt_q == LAST) begin
                    beat_cnt_d = '0;
                    full_d     = 1'b0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            beat_cnt_q <= '0;
            full_q     <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            beat_cnt_q <= beat_cnt_d;
            full_q     <= full_d;
        end
    end

    assign buf_full  = full_q;
    assign word_out  = buf_q;
    assign beat_out  = buf_q[PAD_WIDTH-1:0];
    assign last_beat = (beat_cnt_q == LAST);

endmodule

// File: rtl/gb_if_responder.sv
// Off-chip-side responder for the global-buffer transfer interface.
// Accepts one request at a time from the GB, forwards it to the host, then moves
// BURST_WORDS wide words: read (dir=1) packs pad beats into GB words, write
// (dir=0) splits GB words into pad beats, low beat first.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   CCUIF_reset_all                 sync abort back to IDLE, counters cleared
//   GBIF_cfg_val/info, IFGB_cfg_rdy GB request handshake
//   IFGB_rd_val/data, GBIF_rd_rdy   read word to GB
//   GBIF_wr_val/data, IFGB_wr_rdy   write word from GB
//   IFPAD_req_val/info, PADIF_req_rdy  request to host
//   PADIF_val/data, IFPAD_rdy       host -> chip pad beats
//   IFPAD_val/data, PADIF_rdy       chip -> host pad beats
//   IFCCU_done                      one-cycle pulse on burst completion
module gb_if_responder
    import gb_if_responder_pkg::*;
#(
    parameter int unsigned PORT_WIDTH  = 128,
    parameter int unsigned PAD_WIDTH   = 32,
    parameter int unsigned BURST_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUIF_reset_all,
    input  logic                  GBIF_cfg_val,
    input  logic [INFO_WIDTH-1:0] GBIF_cfg_info,
    output logic                  IFGB_cfg_rdy,
    output logic                  IFGB_rd_val,
    output logic [PORT_WIDTH-1:0] IFGB_rd_data,
    input  logic                  GBIF_rd_rdy,
    input  logic                  GBIF_wr_val,
    input  logic [PORT_WIDTH-1:0] GBIF_wr_data,
    output logic                  IFGB_wr_rdy,
    output logic                  IFPAD_req_val,
    output logic [INFO_WIDTH-1:0] IFPAD_req_info,
    input  logic                  PADIF_req_rdy,
    input  logic                  PADIF_val,
    input  logic [PAD_WIDTH-1:0]  PADIF_data,
    output logic                  IFPAD_rdy,
    output logic                  IFPAD_val,
    output logic [PAD_WIDTH-1:0]  IFPAD_data,
    input  logic                  PADIF_rdy,
    output logic                  IFCCU_done
);

    localparam int unsigned WCNT_W = $clog2(BURST_WORDS + 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BURST_WORDS - 1);
    localparam logic [WCNT_W-1:0] BURST_CNT = WCNT_W'(BURST_WORDS);

    state_e                state_q, state_d;
    logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [INFO_WIDTH-1:0] info_q, info_d;

    conv_mode_e            conv_mode;
    logic                  buf_full;
    logic                  last_beat;
    logic [PORT_WIDTH-1:0] word_out;
    logic [PAD_WIDTH-1:0]  beat_out;
    logic                  pad_beat_in;
    logic                  gb_rd_take;
    logic                  gb_wr_load;
    logic                  pad_beat_take;

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        info_d        = info_q;
        conv_mode     = CONV_PACK;
        IFGB_cfg_rdy  = 1'b0;
        IFPAD_req_val = 1'b0;
        IFGB_rd_val   = 1'b0;
        IFGB_wr_rdy   = 1'b0;
        IFPAD_rdy     = 1'b0;
        IFPAD_val     = 1'b0;
        IFCCU_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                IFGB_cfg_rdy = 1'b1;
                if (GBIF_cfg_val) begin
                    info_d  = GBIF_cfg_info;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                IFPAD_req_val = 1'b1;
                if (PADIF_req_rdy) begin
                    word_cnt_d = '0;
                    state_d    = info_q[DIR_BIT] ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                IFPAD_rdy   = ~buf_full;
                IFGB_rd_val = buf_full;
                if (buf_full && GBIF_rd_rdy) begin
                    if (word_cnt_q == LAST_WORD) begin
                        IFCCU_done = 1'b1;
                        word_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_WR: begin
                conv_mode   = CONV_SPLIT;
                IFGB_wr_rdy = ~buf_full && (word_cnt_q < BURST_CNT);
                IFPAD_val   = buf_full;
                if (buf_full && PADIF_rdy && last_beat) begin
                    if (word_cnt_q == LAST_WORD) begin
                        IFCCU_done = 1'b1;
                        word_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides whatever the state decoded above, including a completing handshake.
        if (CCUIF_reset_all) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
            info_d     = '0;
            IFCCU_done = 1'b0;
        end

        pad_beat_in   = PADIF_val && IFPAD_rdy;
        gb_rd_take    = IFGB_rd_val && GBIF_rd_rdy;
        gb_wr_load    = GBIF_wr_val && IFGB_wr_rdy;
        pad_beat_take = IFPAD_val && PADIF_rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            info_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            info_q     <= info_d;
        end
    end

    if_width_conv #(
        .PORT_WIDTH (PORT_WIDTH),
        .PAD_WIDTH  (PAD_WIDTH)
    ) u_conv (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (CCUIF_reset_all),
        .mode          (conv_mode),
        .beat_in_val   (pad_beat_in),
        .beat_in_data  (PADIF_data),
        .word_take     (gb_rd_take),
        .word_load     (gb_wr_load),
        .word_in       (GBIF_wr_data),
        .beat_out_take (pad_beat_take),
        .buf_full      (buf_full),
        .word_out      (word_out),
        .beat_out      (beat_out),
        .last_beat     (last_beat)
    );

    assign IFGB_rd_data   = (state_q == ST_RD && buf_full) ? word_out : '0;
    assign IFPAD_data     = (state_q == ST_WR && buf_full) ? beat_out : '0;
    assign IFPAD_req_info = info_q;

endmodule
